// File: rtl/phase_gen.sv
// phase_gen: parametrised instruction-cycle timing generator.
//
// Splits each instruction cycle into NPHASE phases of one clk period each. It produces the
// classic timing strobes (clk1, clk2, clk4, fetch, alu_clk) from the phase index. It also
// supports stall, halt at a cycle boundary, start/single-step and a completed-cycle counter.
//
// Ports:
//   clk        in   system clock; all state advances on the falling edge
//   reset      in   asynchronous reset, active-high
//   start      in   level; leave IDLE (when AUTO_START=0) or HALTED
//   stall      in   level; freeze phase and outputs while running
//   halt_req   in   level; stop at the end of the current instruction cycle
//   clk1       out  ~clk (combinational)
//   clk2       out  phase[0]
//   clk4       out  ~phase[1]
//   fetch      out  phase[PW-1], high in the second half of the cycle
//   alu_clk    out  high while ALU_START <= phase < ALU_START+ALU_LEN
//   phase      out  current phase index
//   cyc_start  out  high while phase==0 in RUN
//   running    out  state is RUN
//   cycle_cnt  out  completed instruction cycles, wraps

module phase_gen #(
    parameter int unsigned NPHASE     = 8,
    parameter int unsigned PW         = 3,
    parameter int unsigned ALU_START  = 1,
    parameter int unsigned ALU_LEN    = 2,
    parameter int unsigned CNT_W      = 16,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             halt_req,
    output logic             clk1,
    output logic             clk2,
    output logic             clk4,
    output logic             fetch,
    output logic             alu_clk,
    output logic [PW-1:0]    phase,
    output logic             cyc_start,
    output logic             running,
    output logic [CNT_W-1:0] cycle_cnt
);

    // Reject parameter sets the decode cannot represent.
    if (NPHASE < 4 || (NPHASE & (NPHASE - 1)) != 0 || PW != $clog2(NPHASE) ||
        ALU_START + ALU_LEN > NPHASE || CNT_W < 1) begin : g_bad_params
        $fatal(1, "phase_gen: illegal parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

    localparam logic [PW-1:0] LastPhase = PW'(NPHASE - 1);

    state_e             state_q, state_d;
    logic [PW-1:0]      phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               clk2_q, clk2_d;
    logic               clk4_q, clk4_d;
    logic               fetch_q, fetch_d;
    logic               alu_q, alu_d;
    logic               cyc_q, cyc_d;
    logic [31:0]        phase_d_ext;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (AUTO_START || start) begin
                    state_d = StRun;
                    phase_d = '0;
                end
            end
            StRun: begin
                // A stalled edge holds everything, halt_req included.
                if (!stall) begin
                    if (phase_q != LastPhase) begin
                        phase_d = phase_q + PW'(1);
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        phase_d = '0;
                        if (halt_req) begin
                            state_d = StHalted;
                        end
                    end
                end
            end
            StHalted: begin
                if (start) begin
                    state_d = StRun;
                    phase_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                phase_d = '0;
            end
        endcase
    end

    assign phase_d_ext = 32'(phase_d);

    // Strobes are decoded from the next phase and registered, so they switch glitch-free on
    // the same edge as phase. Outside RUN they sit at their reset values.
    always_comb begin
        clk2_d  = 1'b0;
        clk4_d  = 1'b1;
        fetch_d = 1'b0;
        alu_d   = 1'b0;
        cyc_d   = 1'b0;
        if (state_d == StRun) begin
            clk2_d  = phase_d[0];
            clk4_d  = ~phase_d[1];
            fetch_d = phase_d[PW-1];
            alu_d   = (phase_d_ext >= ALU_START) && (phase_d_ext < ALU_START + ALU_LEN);
            cyc_d   = (phase_d == '0);
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            phase_q <= '0;
            cnt_q   <= '0;
            clk2_q  <= 1'b0;
            clk4_q  <= 1'b1;
            fetch_q <= 1'b0;
            alu_q   <= 1'b0;
            cyc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            clk2_q  <= clk2_d;
            clk4_q  <= clk4_d;
            fetch_q <= fetch_d;
            alu_q   <= alu_d;
            cyc_q   <= cyc_d;
        end
    end

    assign clk1      = ~clk;
    assign clk2      = clk2_q;
    assign clk4      = clk4_q;
    assign fetch     = fetch_q;
    assign alu_clk   = alu_q;
    assign phase     = phase_q;
    assign cyc_start = cyc_q;
    assign running   = (state_q == StRun);
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_phase_gen.sv
// Bench for phase_gen: two instances (default parameters, and a 4-phase/4-bit-counter
// variant with AUTO_START=0) checked against a behavioural model every cycle.
module tb_phase_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start0, stall0, halt0, start1, stall1, halt1;

    logic        d0_clk1, d0_clk2, d0_clk4, d0_fetch, d0_alu, d0_cyc, d0_run;
    logic [2:0]  d0_phase;
    logic [15:0] d0_cnt;
    logic        d1_clk1, d1_clk2, d1_clk4, d1_fetch, d1_alu, d1_cyc, d1_run;
    logic [1:0]  d1_phase;
    logic [3:0]  d1_cnt;

    phase_gen dut0 (
        .clk(clk), .reset(reset), .start(start0), .stall(stall0), .halt_req(halt0),
        .clk1(d0_clk1), .clk2(d0_clk2), .clk4(d0_clk4), .fetch(d0_fetch), .alu_clk(d0_alu),
        .phase(d0_phase), .cyc_start(d0_cyc), .running(d0_run), .cycle_cnt(d0_cnt)
    );

    phase_gen #(
        .NPHASE(4), .PW(2), .ALU_START(3), .ALU_LEN(1), .CNT_W(4), .AUTO_START(1'b0)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start1), .stall(stall1), .halt_req(halt1),
        .clk1(d1_clk1), .clk2(d1_clk2), .clk4(d1_clk4), .fetch(d1_fetch), .alu_clk(d1_alu),
        .phase(d1_phase), .cyc_start(d1_cyc), .running(d1_run), .cycle_cnt(d1_cnt)
    );

    // Reference model: per-instance parameters and state.
    localparam int Idle = 0, Run = 1, Halted = 2;
    int np    [2] = '{8, 4};
    int als   [2] = '{1, 3};
    int all   [2] = '{2, 1};
    int cw    [2] = '{16, 4};
    int autos [2] = '{1, 0};
    int m_state [2];
    int m_phase [2];
    int m_cnt   [2];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = Idle;
            m_phase[k] = 0;
            m_cnt[k]   = 0;
        end
    endfunction

    function automatic void model_step(int k, bit st, bit sl, bit h);
        case (m_state[k])
            Idle: if (autos[k] != 0 || st) begin
                m_state[k] = Run;
                m_phase[k] = 0;
            end
            Run: if (!sl) begin
                if (m_phase[k] < np[k] - 1) m_phase[k]++;
                else begin
                    m_cnt[k]   = (m_cnt[k] + 1) % (1 << cw[k]);
                    m_phase[k] = 0;
                    if (h) m_state[k] = Halted;
                end
            end
            default: if (st) begin
                m_state[k] = Run;
                m_phase[k] = 0;
            end
        endcase
    endfunction

    // {running, phase[2:0], clk2, clk4, fetch, alu_clk, cyc_start, cycle_cnt[15:0]}
    function automatic logic [24:0] exp_vec(int k);
        int p;
        p = m_phase[k];
        if (m_state[k] != Run) return {1'b0, 3'd0, 1'b0, 1'b1, 3'b000, 16'(m_cnt[k])};
        return {1'b1, 3'(p), 1'(p % 2), 1'((p / 2) % 2 == 0), 1'(p >= np[k] / 2),
                1'(p >= als[k] && p < als[k] + all[k]), 1'(p == 0), 16'(m_cnt[k])};
    endfunction

    function automatic logic [24:0] obs_vec(int k);
        if (k == 0)
            return {d0_run, d0_phase, d0_clk2, d0_clk4, d0_fetch, d0_alu, d0_cyc, d0_cnt};
        return {d1_run, 1'b0, d1_phase, d1_clk2, d1_clk4, d1_fetch, d1_alu, d1_cyc, 12'd0, d1_cnt};
    endfunction

    // One falling edge; returns at posedge+1 where outputs are sampled.
    task automatic edge_step();
        @(negedge clk);
        if (!reset) begin
            model_step(0, start0, stall0, halt0);
            model_step(1, start1, stall1, halt1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        {start0, stall0, halt0, start1, stall1, halt1} = '0;
        model_reset();
        @(posedge clk);
        #1;
        edge_step();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k))
                $display("FAIL reset dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
            else n_pass++;
        end
        n_checks++;
        if ({d0_clk1, d1_clk1} !== {2{~clk}})
            $display("FAIL reset_clk1: got %b%b want %b", d0_clk1, d1_clk1, ~clk);
        else n_pass++;
    endtask

    task automatic test_free_run();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            model_step(0, start0, stall0, halt0);
            model_step(1, start1, stall1, halt1);
            #1;
            n_checks++;
            if ({d0_clk1, d1_clk1} !== {2{~clk}})
                $display("FAIL free_run_clk1 i=%0d: got %b%b want %b", i, d0_clk1, d1_clk1, ~clk);
            else n_pass++;
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec(k) !== exp_vec(k))
                    $display("FAIL free_run dut%0d i=%0d: got %h want %h", k, i, obs_vec(k), exp_vec(k));
                else n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 16 && m_phase[0] != 5; i++) edge_step();
        n_checks++;
        if (m_phase[0] != 5) $display("FAIL stall_reach_phase5: got %0d want 5", m_phase[0]);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            stall0 = (i < 3);
            edge_step();
            n_checks++;
            if (obs_vec(0) !== exp_vec(0))
                $display("FAIL stall_hold i=%0d: got %h want %h", i, obs_vec(0), exp_vec(0));
            else n_pass++;
        end
        for (int i = 0; i < 40; i++) begin
            stall0 = ($urandom % 3 == 0);
            edge_step();
            n_checks++;
            if (obs_vec(0) !== exp_vec(0))
                $display("FAIL stall_random i=%0d: got %h want %h", i, obs_vec(0), exp_vec(0));
            else n_pass++;
        end
        stall0 = 1'b0;
    endtask

    task automatic test_halt();
        for (int i = 0; i < 16 && !(m_state[0] == Run && m_phase[0] == 3); i++) edge_step();
        halt0 = 1'b1;
        for (int i = 0; i < 20 && m_state[0] != Halted; i++) begin
            edge_step();
            n_checks++;
            if (obs_vec(0) !== exp_vec(0))
                $display("FAIL halt i=%0d: got %h want %h", i, obs_vec(0), exp_vec(0));
            else n_pass++;
        end
        n_checks++;
        if (d0_run !== 1'b0) $display("FAIL halt_reached: running got %b want 0", d0_run);
        else n_pass++;
        // stall has no effect while halted
        for (int i = 0; i < 5; i++) begin
            stall0 = $urandom % 2;
            edge_step();
            n_checks++;
            if (obs_vec(0) !== exp_vec(0))
                $display("FAIL halted_hold i=%0d: got %h want %h", i, obs_vec(0), exp_vec(0));
            else n_pass++;
        end
        stall0 = 1'b0;
    endtask

    task automatic test_single_step();
        start0 = 1'b1;
        edge_step();
        start0 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (obs_vec(0) !== exp_vec(0))
                $display("FAIL single_step i=%0d: got %h want %h", i, obs_vec(0), exp_vec(0));
            else n_pass++;
            edge_step();
        end
        halt0 = 1'b0;
    endtask

    task automatic test_reset_midcycle();
        start0 = 1'b1;
        edge_step();
        start0 = 1'b0;
        for (int i = 0; i < 16 && m_phase[0] != 6; i++) edge_step();
        reset = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k))
                $display("FAIL async_reset dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
            else n_pass++;
        end
        edge_step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            edge_step();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec(k) !== exp_vec(k))
                    $display("FAIL post_reset dut%0d i=%0d: got %h want %h", k, i, obs_vec(k), exp_vec(k));
                else n_pass++;
            end
        end
        start1 = 1'b1;
        edge_step();
        start1 = 1'b0;
        n_checks++;
        if (obs_vec(1) !== exp_vec(1))
            $display("FAIL idle_start: got %h want %h", obs_vec(1), exp_vec(1));
        else n_pass++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 68; i++) begin
            edge_step();
            n_checks++;
            if (obs_vec(1) !== exp_vec(1))
                $display("FAIL wrap i=%0d: got %h want %h", i, obs_vec(1), exp_vec(1));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            start0 = ($urandom % 4 == 0);
            stall0 = ($urandom % 4 == 0);
            halt0  = ($urandom % 8 == 0);
            start1 = ($urandom % 4 == 0);
            stall1 = ($urandom % 4 == 0);
            halt1  = ($urandom % 6 == 0);
            edge_step();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec(k) !== exp_vec(k))
                    $display("FAIL random dut%0d i=%0d: got %h want %h", k, i, obs_vec(k), exp_vec(k));
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_halt();
        test_single_step();
        test_reset_midcycle();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
